dsp48_arbiter: RTL
==================

DSP48_ARBITER -- requirements
Module: dsp48_arbiter

Interface
REQ-001 SHALL have parameter A_WIDTH, default 24, signed multiplicand width (2..30).
REQ-002 SHALL have parameter B_WIDTH, default 16, signed multiplier width (2..18).
REQ-003 SHALL have parameter P_WIDTH, default 24, rounded result width; SHIFT = A_WIDTH+B_WIDTH-P_WIDTH-1 >= 2.
REQ-004 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-005 SHALL have port aclk, input, 1, sole clock, all logic on rising edge.
REQ-006 SHALL have port areset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port s_axis_tdata, input, NREQ*(A_WIDTH+B_WIDTH), per-requester {B,A} operand pair, requester i at slice i.
REQ-008 SHALL have ports s_axis_tvalid / s_axis_tready, input / output, NREQ each, per-requester operand handshake.
REQ-009 SHALL have port m_axis_tdata, output, NREQ*P_WIDTH, per-requester rounded product.
REQ-010 SHALL have ports m_axis_tvalid / m_axis_tready, output / input, NREQ each, per-requester result handshake.

Function
REQ-011 SHALL share one pipelined multiply-round unit among NREQ requesters; at most one operand pair accepted per cycle.
REQ-012 SHALL mark requester i eligible when s_axis_tvalid[i]=1 and busy[i]=0.
REQ-013 SHALL drive s_axis_tready one-hot or zero, combinationally, granting the first eligible requester at or after pointer ptr, wrapping modulo NREQ.
REQ-014 SHALL update ptr to (g+1) mod NREQ on a grant to g; ptr unchanged on cycles without a grant.
REQ-015 SHALL set busy[g] on grant; clear busy[i] on m_axis_tvalid[i]&m_axis_tready[i] (one outstanding op per requester).
REQ-016 SHALL register operands and requester tag on accept (stage 1), register full A_WIDTH+B_WIDTH product (stage 2), register rounded result and tag (stage 3).
REQ-017 SHALL assert m_axis_tvalid[tag] exactly 3 cycles after the accepting edge; data held stable until m_axis_tready[tag]=1.
REQ-018 SHALL sustain one accept per cycle across distinct requesters; a requester's results return in its own accept order.
REQ-019 SHALL return P = product bits [SHIFT+P_WIDTH-1:SHIFT], rounded per REQ-024/025; bits above P_WIDTH+SHIFT discarded (no saturation).
REQ-020 SHALL not grant when all eligible bits are zero; output registers not written by a bubble stage.
REQ-021 SHALL tolerate a result handshake and a new grant to the same requester in the same cycle only if busy cleared beforehand (no same-cycle re-grant).

Reset
REQ-022 SHALL, on areset=1, asynchronously clear busy, ptr=0, all stage valids, m_axis_tvalid=0, m_axis_tdata=0; in-flight operations discarded.
REQ-023 SHALL drive s_axis_tready=0 while areset=1; first grant possible on the first edge after release.

Configuration
REQ-024 With DSP48_ARB_ROUND_EN defined, SHALL apply convergent rounding (round half to even) on the SHIFT dropped bits.
REQ-025 Without DSP48_ARB_ROUND_EN, SHALL truncate (floor, two's complement) the dropped bits; latency unchanged.

Structure
REQ-026 SHALL place SHIFT computation, tag width ($clog2(NREQ)) and stage-count constant (3) in package dsp48_arb_pkg.
REQ-027 SHALL instantiate one sub-module mult_round (stages 2-3 plus rounding); arbitration, busy, ptr and output registers in dsp48_arbiter.

Verification (A_WIDTH=24, B_WIDTH=16, P_WIDTH=24, NREQ=4, SHIFT=15)
REQ-028 Req0 A=3, B=0x4000 accepted at cycle 10 -> m_axis_tvalid[0] at cycle 13, data 2 with ROUND_EN, 1 without.
REQ-029 Req1 A=0xFFFFFF, B=0x4000 -> data 0 with ROUND_EN, 0xFFFFFF without; Req1 A=1, B=0x4000 -> 0 both builds.
REQ-030 All four tvalid held high from reset release -> grants 0,1,2,3 on consecutive cycles, no re-grant until each result drained.
REQ-031 Req2 m_axis_tready=0 for 20 cycles -> data held stable, s_axis_tready[2]=0 throughout, others served normally.
REQ-032 areset pulsed with 3 ops in flight -> no m_axis_tvalid afterwards, ptr=0, next grant to lowest eligible index.

Source files
------------

// File: rtl/dsp48_arb_pkg.sv
// rtl/dsp48_arb_pkg.sv - shared constants and sizing helpers for dsp48_arbiter
package dsp48_arb_pkg;

    localparam int NUM_STAGES = 3;

    function automatic int calc_shift(input int a_w, input int b_w, input int p_w);
        return a_w + b_w - p_w - 1;
    endfunction

    function automatic int tag_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dsp48_arbiter_mult_round.sv
// rtl/dsp48_arbiter_mult_round.sv - product (stage 2) and rounded result (stage 3) registers
// DSP48_ARB_ROUND_EN selects round-half-to-even; otherwise the dropped bits are floored.
module mult_round
    import dsp48_arb_pkg::*;
#(
    parameter int A_WIDTH = 24,
    parameter int B_WIDTH = 16,
    parameter int P_WIDTH = 24,
    parameter int TAG_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [A_WIDTH-1:0] in_a,
    input  logic signed [B_WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    output logic [P_WIDTH-1:0]        out_data,
    output logic [TAG_W-1:0]          out_tag
);

    localparam int W     = A_WIDTH + B_WIDTH;
    localparam int SHIFT = calc_shift(A_WIDTH, B_WIDTH, P_WIDTH);

    logic signed [W-1:0] mul;
    logic [W-1:0]        prod_d, prod_q;
    logic                s2_valid_d, s2_valid_q;
    logic [TAG_W-1:0]    s2_tag_d, s2_tag_q;
    logic [P_WIDTH-1:0]  res_d, res_q;
    logic                s3_valid_d, s3_valid_q;
    logic [TAG_W-1:0]    s3_tag_d, s3_tag_q;

`ifdef DSP48_ARB_ROUND_EN
    // Adding (half - 1 + kept lsb) carries into the kept field exactly when
    // the remainder exceeds half, or equals half with an odd kept value.
    localparam logic [W-1:0] HALF_M1 = (W'(1) << (SHIFT - 1)) - W'(1);
    logic [W-1:0] rsum;
    logic         unused_bits;
    assign unused_bits = ^{rsum[W-1], rsum[SHIFT-1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{prod_q[W-1], prod_q[SHIFT-1:0]};
`endif

    always_comb begin
        mul        = in_a * in_b;
        s2_valid_d = in_valid;
        s2_tag_d   = in_valid ? in_tag : s2_tag_q;
        prod_d     = in_valid ? mul : prod_q;
        s3_valid_d = s2_valid_q;
        s3_tag_d   = s2_valid_q ? s2_tag_q : s3_tag_q;
`ifdef DSP48_ARB_ROUND_EN
        rsum  = prod_q + HALF_M1 + W'(prod_q[SHIFT]);
        res_d = s2_valid_q ? rsum[SHIFT+P_WIDTH-1:SHIFT] : res_q;
`else
        res_d = s2_valid_q ? prod_q[SHIFT+P_WIDTH-1:SHIFT] : res_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_tag_q   <= '0;
            res_q      <= '0;
            s3_valid_q <= 1'b0;
            s3_tag_q   <= '0;
        end else begin
            prod_q     <= prod_d;
            s2_valid_q <= s2_valid_d;
            s2_tag_q   <= s2_tag_d;
            res_q      <= res_d;
            s3_valid_q <= s3_valid_d;
            s3_tag_q   <= s3_tag_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign out_data  = res_q;
    assign out_tag   = s3_tag_q;

endmodule

// File: rtl/dsp48_arbiter.sv
// rtl/dsp48_arbiter.sv - round-robin sharing of one multiply-round pipeline among NREQ requesters
// Rounding mode follows DSP48_ARB_ROUND_EN inside mult_round.
module dsp48_arbiter
    import dsp48_arb_pkg::*;
#(
    parameter int A_WIDTH = 24,
    parameter int B_WIDTH = 16,
    parameter int P_WIDTH = 24,
    parameter int NREQ    = 4
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [NREQ*(A_WIDTH+B_WIDTH)-1:0] s_axis_tdata,
    input  logic [NREQ-1:0]                   s_axis_tvalid,
    output logic [NREQ-1:0]                   s_axis_tready,
    output logic [NREQ*P_WIDTH-1:0]           m_axis_tdata,
    output logic [NREQ-1:0]                   m_axis_tvalid,
    input  logic [NREQ-1:0]                   m_axis_tready
);

    localparam int OPW   = A_WIDTH + B_WIDTH;
    localparam int TAG_W = tag_width(NREQ);

    logic [NREQ-1:0]         busy_d, busy_q;
    logic [TAG_W-1:0]        ptr_d, ptr_q;
    logic [NREQ-1:0]         elig, gnt;
    logic                    gnt_any;
    logic [TAG_W-1:0]        gnt_idx, cand;
    logic [OPW-1:0]          op_sel;
    logic                    s1_valid_d, s1_valid_q;
    logic [A_WIDTH-1:0]      s1_a_d, s1_a_q;
    logic [B_WIDTH-1:0]      s1_b_d, s1_b_q;
    logic [TAG_W-1:0]        s1_tag_d, s1_tag_q;
    logic                    mr_valid;
    logic [P_WIDTH-1:0]      mr_data;
    logic [TAG_W-1:0]        mr_tag;
    logic [NREQ-1:0]         mvalid_d, mvalid_q;
    logic [NREQ*P_WIDTH-1:0] mdata_d, mdata_q;

    // Busy is the registered value, so a requester draining its result this
    // cycle cannot be re-granted until the following cycle.
    always_comb begin
        elig    = s_axis_tvalid & ~busy_q;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = TAG_W'((int'(ptr_q) + i) % NREQ);
            if (!gnt_any && elig[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_any = gnt_any & ~areset;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end

        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == TAG_W'(NREQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
        end
        busy_d = (busy_q & ~(mvalid_q & m_axis_tready)) | gnt;

        op_sel     = s_axis_tdata[gnt_idx*OPW +: OPW];
        s1_valid_d = gnt_any;
        s1_a_d     = gnt_any ? op_sel[A_WIDTH-1:0]   : s1_a_q;
        s1_b_d     = gnt_any ? op_sel[OPW-1:A_WIDTH] : s1_b_q;
        s1_tag_d   = gnt_any ? gnt_idx               : s1_tag_q;
    end

    mult_round #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH),
        .P_WIDTH (P_WIDTH),
        .TAG_W   (TAG_W)
    ) u_mult_round (
        .clk       (aclk),
        .rst       (areset),
        .in_valid  (s1_valid_q),
        .in_a      (s1_a_q),
        .in_b      (s1_b_q),
        .in_tag    (s1_tag_q),
        .out_valid (mr_valid),
        .out_data  (mr_data),
        .out_tag   (mr_tag)
    );

    // One outstanding op per requester keeps its output slot free on arrival.
    always_comb begin
        mvalid_d = mvalid_q;
        mdata_d  = mdata_q;
        for (int i = 0; i < NREQ; i++) begin
            if (mvalid_q[i] && m_axis_tready[i]) begin
                mvalid_d[i] = 1'b0;
            end
            if (mr_valid && mr_tag == TAG_W'(i)) begin
                mvalid_d[i]                   = 1'b1;
                mdata_d[i*P_WIDTH +: P_WIDTH] = mr_data;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            busy_q     <= '0;
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
            mvalid_q   <= '0;
            mdata_q    <= '0;
        end else begin
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_tag_q   <= s1_tag_d;
            mvalid_q   <= mvalid_d;
            mdata_q    <= mdata_d;
        end
    end

    assign s_axis_tready = gnt;
    assign m_axis_tvalid = mvalid_q;
    assign m_axis_tdata  = mdata_q;

endmodule
